// File: rtl/telem_frame_sched.sv
// Periodic telemetry frame scheduler: reads sensor bytes FIRST_ADDR..LAST_ADDR and streams a framed
// packet to UART TX. Define TELEM_CHECKSUM_EN to append a two's-complement checksum byte.
module telem_frame_sched #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter logic [7:0]  FIRST_ADDR    = 8'd1,
    parameter logic [7:0]  LAST_ADDR     = 8'd25,
    parameter logic [7:0]  SYNC0         = 8'hA5,
    parameter logic [7:0]  SYNC1         = 8'h5A
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    output logic [7:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] frame_cnt,
    output logic       overrun
);

    localparam logic [23:0] PeriodLast = 24'(PERIOD_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSync0,
        StSync1,
        StCnt,
        StFetch,
`ifdef TELEM_CHECKSUM_EN
        StSend,
        StCsum
`else
        StSend
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [23:0] period_q, period_d;
    logic [7:0]  reg_addr_q, reg_addr_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        overrun_q, overrun_d;
    logic        tick;
    logic        xfer;
    logic        frame_done;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign xfer = tx_valid_q & tx_ready;

    // Period counter is held at zero while disabled, so re-enabling restarts a full period.
    always_comb begin
        tick     = 1'b0;
        period_d = period_q;
        if (!enable) begin
            period_d = '0;
        end else if (period_q == PeriodLast) begin
            period_d = '0;
            tick     = 1'b1;
        end else begin
            period_d = period_q + 24'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        reg_addr_d  = reg_addr_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        // busy_q is still high on the frame-end edge, so a coincident tick counts as overrun.
        overrun_d   = tick & busy_q;
        frame_done  = 1'b0;
`ifdef TELEM_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d    = StSync0;
                    tx_data_d  = SYNC0;
                    tx_valid_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            StSync0: begin
                if (xfer) begin
                    state_d   = StSync1;
                    tx_data_d = SYNC1;
                end
            end
            StSync1: begin
                if (xfer) begin
                    state_d   = StCnt;
                    tx_data_d = frame_cnt_q;
                end
            end
            StCnt: begin
                if (xfer) begin
                    state_d    = StFetch;
                    reg_addr_d = FIRST_ADDR;
                    tx_valid_d = 1'b0;
`ifdef TELEM_CHECKSUM_EN
                    sum_d      = frame_cnt_q;
`endif
                end
            end
            StFetch: begin
                state_d    = StSend;
                tx_data_d  = reg_data;
                tx_valid_d = 1'b1;
`ifdef TELEM_CHECKSUM_EN
                sum_d      = sum_q + reg_data;
`endif
            end
            StSend: begin
                if (xfer) begin
                    if (reg_addr_q < LAST_ADDR) begin
                        state_d    = StFetch;
                        reg_addr_d = reg_addr_q + 8'd1;
                        tx_valid_d = 1'b0;
                    end else begin
`ifdef TELEM_CHECKSUM_EN
                        state_d   = StCsum;
                        tx_data_d = 8'd0 - sum_q;
`else
                        frame_done = 1'b1;
`endif
                    end
                end
            end
`ifdef TELEM_CHECKSUM_EN
            StCsum: begin
                if (xfer) begin
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase

        if (frame_done) begin
            state_d     = StIdle;
            frame_cnt_d = frame_cnt_q + 8'd1;
            reg_addr_d  = '0;
            tx_valid_d  = 1'b0;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            period_q    <= '0;
            reg_addr_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
`ifdef TELEM_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            reg_addr_q  <= reg_addr_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
`ifdef TELEM_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign reg_addr  = reg_addr_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_telem_frame_sched.sv
// Directed bench for telem_frame_sched: one instance at period 100, one at period 64 for overrun
// and wrap scenarios; a shared tx_ready drives both, sel picks which one is observed.
module tb_telem_frame_sched;

`ifdef TELEM_CHECKSUM_EN
    localparam int FrameLen = 29;
    localparam int BusyFall = 53 + 1;
`else
    localparam int FrameLen = 28;
    localparam int BusyFall = 53;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       enable64 = 1'b0;
    logic       tx_ready = 1'b1;
    logic       sel = 1'b0;

    logic [7:0] reg_addr, reg_data, tx_data, frame_cnt;
    logic       tx_valid, busy, overrun;
    logic [7:0] reg_addr64, reg_data64, tx_data64, frame_cnt64;
    logic       tx_valid64, busy64, overrun64;

    logic       mon_valid, mon_overrun;
    logic [7:0] mon_data, mon_addr;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    int         start_cyc, last_xfer_cyc, stall_errs, ovr_pulses;
    logic [7:0] got[$];
    logic [7:0] addr_seq[$];

    telem_frame_sched #(.PERIOD_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .enable(enable), .reg_addr(reg_addr), .reg_data(reg_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
        .frame_cnt(frame_cnt), .overrun(overrun)
    );

    telem_frame_sched #(.PERIOD_CYCLES(64)) dut64 (
        .clk(clk), .rst(rst), .enable(enable64), .reg_addr(reg_addr64), .reg_data(reg_data64),
        .tx_data(tx_data64), .tx_valid(tx_valid64), .tx_ready(tx_ready), .busy(busy64),
        .frame_cnt(frame_cnt64), .overrun(overrun64)
    );

    // Sensor register file model: byte at address a is 3*a.
    assign reg_data   = reg_addr * 8'd3;
    assign reg_data64 = reg_addr64 * 8'd3;

    assign mon_valid   = sel ? tx_valid64 : tx_valid;
    assign mon_data    = sel ? tx_data64 : tx_data;
    assign mon_addr    = sel ? reg_addr64 : reg_addr;
    assign mon_overrun = sel ? overrun64 : overrun;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] exp_byte(input logic [7:0] cnt, input int i);
        logic [7:0] s;
        if (i == 0) return 8'hA5;
        if (i == 1) return 8'h5A;
        if (i == 2) return cnt;
        if (i < 28) return 8'((i - 2) * 3);
        s = cnt;
        for (int k = 1; k <= 25; k++) s = s + 8'(k * 3);
        return 8'd0 - s;
    endfunction

    // -1 when the captured frame is exactly right, else the first bad index (or the length).
    function automatic int frame_mismatch(input logic [7:0] cnt);
        if (got.size() != FrameLen) return got.size();
        for (int i = 0; i < FrameLen; i++) begin
            if (got[i] !== exp_byte(cnt, i)) return i;
        end
        return -1;
    endfunction

    // mode 0: ready=1; 1: ready 1-of-3; 2: ready low 40 cycles from byte 10; 3: drop enable at
    // payload byte 10. Returns at the negedge before the stop_after-th transfer's edge.
    task automatic collect_frame(input int mode, input int stop_after, output bit ok);
        int         first_c;
        bit         prev_stall;
        logic [7:0] prev_data;
        logic [7:0] last_addr;
        got.delete();
        addr_seq.delete();
        ok = 1'b0;
        first_c = -1;
        prev_stall = 1'b0;
        prev_data = '0;
        last_addr = '0;
        stall_errs = 0;
        ovr_pulses = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            case (mode)
                1: tx_ready = (c % 3 == 0);
                2: tx_ready = !(first_c >= 0 && c >= first_c + 10 && c < first_c + 50);
                default: tx_ready = 1'b1;
            endcase
            if (mon_overrun) ovr_pulses++;
            if (mon_addr != last_addr && mon_addr != 8'd0) addr_seq.push_back(mon_addr);
            last_addr = mon_addr;
            if (prev_stall && (!mon_valid || mon_data !== prev_data)) stall_errs++;
            if (mon_valid && first_c < 0) begin
                first_c = c;
                start_cyc = cyc;
            end
            prev_stall = mon_valid && !tx_ready;
            prev_data = mon_data;
            if (mon_valid && tx_ready) begin
                got.push_back(mon_data);
                last_xfer_cyc = cyc + 1;
                if (mode == 3 && got.size() == 13) enable = 1'b0;
                if (got.size() == stop_after) begin
                    ok = 1'b1;
                    return;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({tx_valid, busy, overrun} !== 3'b000)
            $display("FAIL reset_flags: got valid/busy/overrun=%b want 000", {tx_valid, busy, overrun});
        else n_pass++;
        n_checks++;
        if (reg_addr !== 8'd0) $display("FAIL reset_reg_addr: got %h want 00", reg_addr);
        else n_pass++;
        n_checks++;
        if (tx_data !== 8'd0) $display("FAIL reset_tx_data: got %h want 00", tx_data);
        else n_pass++;
        n_checks++;
        if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %h want 00", frame_cnt);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        int c0, s0, r;
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
        collect_frame(0, FrameLen, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL basic_f0_done: got %0d bytes want %0d", got.size(), FrameLen);
        else n_pass++;
        n_checks++;
        if (start_cyc - c0 !== 100) $display("FAIL basic_first_start: got %0d want 100", start_cyc - c0);
        else n_pass++;
        r = frame_mismatch(8'd0);
        n_checks++;
        if (r !== -1) $display("FAIL basic_f0_bytes: bad index %0d want -1", r);
        else n_pass++;
        n_checks++;
        if (last_xfer_cyc - start_cyc !== BusyFall)
            $display("FAIL basic_last_edge: got E%0d want E%0d", last_xfer_cyc - start_cyc, BusyFall);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, tx_valid, reg_addr} !== 10'd0)
            $display("FAIL basic_idle_after: got busy=%b valid=%b addr=%h want 0,0,00", busy,
                     tx_valid, reg_addr);
        else n_pass++;
        n_checks++;
        if (frame_cnt !== 8'd1) $display("FAIL basic_frame_cnt: got %h want 01", frame_cnt);
        else n_pass++;
        s0 = start_cyc;
        collect_frame(0, FrameLen, ok);
        n_checks++;
        if (ok !== 1'b1 || start_cyc - s0 !== 100)
            $display("FAIL basic_f1_period: ok=%b got %0d want 100", ok, start_cyc - s0);
        else n_pass++;
        r = frame_mismatch(8'd1);
        n_checks++;
        if (r !== -1) $display("FAIL basic_f1_bytes: bad index %0d want -1", r);
        else n_pass++;
    endtask

    task automatic test_stall();
        bit ok;
        int r, bad;
        collect_frame(1, FrameLen, ok);
        r = frame_mismatch(8'd2);
        n_checks++;
        if (ok !== 1'b1 || r !== -1) $display("FAIL stall_bytes: ok=%b bad index %0d want -1", ok, r);
        else n_pass++;
        n_checks++;
        if (stall_errs !== 0) $display("FAIL stall_hold: got %0d unstable cycles want 0", stall_errs);
        else n_pass++;
        bad = (addr_seq.size() == 25) ? 0 : 1;
        for (int i = 0; i < addr_seq.size() && i < 25; i++) begin
            if (addr_seq[i] !== 8'(i + 1)) bad++;
        end
        n_checks++;
        if (bad !== 0)
            $display("FAIL stall_addr_seq: got %0d addrs with %0d errors want 1..25", addr_seq.size(), bad);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit ok;
        int r, stray, c0;
        collect_frame(3, FrameLen, ok);
        r = frame_mismatch(8'd3);
        n_checks++;
        if (ok !== 1'b1 || r !== -1) $display("FAIL endrop_frame: ok=%b bad index %0d want -1", ok, r);
        else n_pass++;
        stray = 0;
        repeat (250) begin
            @(negedge clk);
            if (tx_valid || busy) stray++;
        end
        n_checks++;
        if (stray !== 0) $display("FAIL endrop_quiet: got %0d active cycles want 0", stray);
        else n_pass++;
        enable = 1'b1;
        c0 = cyc;
        collect_frame(0, FrameLen, ok);
        enable = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || start_cyc - c0 !== 100)
            $display("FAIL endrop_restart: ok=%b got %0d want 100", ok, start_cyc - c0);
        else n_pass++;
        r = frame_mismatch(8'd4);
        n_checks++;
        if (r !== -1) $display("FAIL endrop_next_bytes: bad index %0d want -1", r);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int r, c0;
        @(negedge clk);
        enable = 1'b1;
        collect_frame(0, 14, ok);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (ok !== 1'b1 || {tx_valid, reg_addr, tx_data} !== {1'b1, 8'd12, 8'd36})
            $display("FAIL rstmid_byte12: got valid=%b addr=%h data=%h want 1,0c,24", tx_valid,
                     reg_addr, tx_data);
        else n_pass++;
        tx_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_valid, busy, reg_addr, frame_cnt, tx_data} !== 26'd0)
            $display("FAIL rstmid_async: got valid=%b busy=%b addr=%h cnt=%h data=%h want all 0",
                     tx_valid, busy, reg_addr, frame_cnt, tx_data);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tx_ready = 1'b1;
        c0 = cyc;
        collect_frame(0, FrameLen, ok);
        enable = 1'b0;
        r = frame_mismatch(8'd0);
        n_checks++;
        if (ok !== 1'b1 || r !== -1 || start_cyc - c0 !== 100)
            $display("FAIL rstmid_next_frame: ok=%b bad index %0d start %0d want -1,100", ok, r,
                     start_cyc - c0);
        else n_pass++;
    endtask

    task automatic test_overrun();
        bit ok;
        int r, c0, s;
        sel = 1'b1;
        @(negedge clk);
        enable64 = 1'b1;
        c0 = cyc;
        collect_frame(2, FrameLen, ok);
        r = frame_mismatch(8'd0);
        n_checks++;
        if (ok !== 1'b1 || r !== -1) $display("FAIL ovr_frame_intact: ok=%b bad index %0d want -1", ok, r);
        else n_pass++;
        n_checks++;
        if (ovr_pulses !== 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_pulses);
        else n_pass++;
        s = start_cyc;
        collect_frame(0, FrameLen, ok);
        r = frame_mismatch(8'd1);
        n_checks++;
        if (ok !== 1'b1 || start_cyc - s !== 128 || r !== -1)
            $display("FAIL ovr_next_start: ok=%b got %0d bad index %0d want 128,-1", ok,
                     start_cyc - s, r);
        else n_pass++;
        n_checks++;
        if (start_cyc - c0 - 128 !== 64 || ovr_pulses !== 0)
            $display("FAIL ovr_quiet_frame: start %0d pulses %0d want 192,0", start_cyc - c0,
                     ovr_pulses);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit   ok;
        int   errs, gap_errs, prev;
        bit   saw_wrap;
        logic [7:0] prev_cnt;
        errs = 0;
        gap_errs = 0;
        saw_wrap = 1'b0;
        prev = start_cyc;
        prev_cnt = 8'd1;
        for (int i = 0; i < 256; i++) begin
            collect_frame(0, FrameLen, ok);
            if (ok !== 1'b1 || frame_mismatch(8'(2 + i)) != -1) errs++;
            if (start_cyc - prev != 64) gap_errs++;
            if (got.size() > 2) begin
                if (prev_cnt == 8'hFF && got[2] == 8'h00) saw_wrap = 1'b1;
                prev_cnt = got[2];
            end
            prev = start_cyc;
        end
        n_checks++;
        if (errs !== 0) $display("FAIL wrap_cnt_bytes: got %0d bad frames want 0", errs);
        else n_pass++;
        n_checks++;
        if (gap_errs !== 0) $display("FAIL wrap_period: got %0d bad gaps want 0", gap_errs);
        else n_pass++;
        n_checks++;
        if (saw_wrap !== 1'b1) $display("FAIL wrap_seen: got %b want 1", saw_wrap);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (frame_cnt64 !== 8'd2) $display("FAIL wrap_final_cnt: got %h want 02", frame_cnt64);
        else n_pass++;
        enable64 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_enable_drop();
        test_reset_mid();
        test_overrun();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
